// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  // True when the byte address falls inside the populated ROM words.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned size_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (word_idx < size_words);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order instruction queue with registered head and flush.
// The head entry drives decode directly, so no combinational path reaches it.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count;
  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic         pop_eff;
  logic         push_eff;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign head     = head_q;

  // Occupancy: flush wins, simultaneous push and pop leave it unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head slot: refilled from the tail on pop, or straight from the push when the tail is empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
    end else if (!flush) begin
      if (pop_eff) begin
        if (count == 2'd2) begin
          head_q <= tail_q;
        end else if (push_eff) begin
          head_q <= push_entry;
        end
      end else if (push_eff && (count == 2'd0)) begin
        head_q <= push_entry;
      end
    end
  end

  // Tail slot: data only, its validity is tracked by count.
  always_ff @(posedge clock) begin
    if (!flush && push_eff &&
        (((count == 2'd1) && !pop_eff) || ((count == 2'd2) && pop_eff))) begin
      tail_q <= push_entry;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of the instruction ROM: owns the pc, pushes
// {pc, rom_data} into a 2-entry queue, handles redirects and halts past the ROM end.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects halt and raise
// misaligned_fault; without it redirect targets are forced word-aligned.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned ROM_SIZE_WORDS = 32,
  parameter int          QUEUE_DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misaligned_fault
);

  logic [31:0]  pc;
  fetch_state_t state;
  logic         pc_in_range;
  logic         q_full;
  logic         q_empty;
  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [31:0]  redirect_target;
  logic         redirect_misaligned;
  logic         redirect_halt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target     = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_misaligned = 1'b0;
`endif

  assign redirect_halt = redirect_misaligned ||
                         !addr_in_range(redirect_target, ROM_SIZE_WORDS);
  assign pc_in_range   = addr_in_range(pc, ROM_SIZE_WORDS);

  assign out_valid = !q_empty;
  assign pop       = !redirect_valid && out_valid && out_ready;
  assign push      = !redirect_valid && (state == RUN) && pc_in_range &&
                     (!q_full || pop);
  assign push_entry      = '{pc: pc, instruction: rom_data};
  assign rom_address     = pc;
  assign out_pc          = head.pc;
  assign out_instruction = head.instruction;
  assign halted          = (state == HALT);

  // pc and run/halt state: redirect first, then range check, then advance on push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      state <= redirect_halt ? HALT : RUN;
    end else if (state == RUN) begin
      if (!pc_in_range) begin
        state <= HALT;
      end else if (push) begin
        pc <= pc + 32'(INSTR_BYTES);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Fault is sticky until an aligned, in-range redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misaligned_fault <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_misaligned) begin
        misaligned_fault <= 1'b1;
      end else if (!redirect_halt) begin
        misaligned_fault <= 1'b0;
      end
    end
  end
`else
  assign misaligned_fault = 1'b0;
`endif

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a combinational ROM model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        halted;
  logic        misaligned_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  instruction_fetch #(
    .RESET_PC       (32'h0000_0000),
    .ROM_SIZE_WORDS (32),
    .QUEUE_DEPTH    (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rom_address      (rom_address),
    .rom_data         (rom_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .halted           (halted),
    .misaligned_fault (misaligned_fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h00b00093;
    return 32'hA000_0000 ^ a;
  endfunction

  always_comb rom_data = rom_word(rom_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset over two edges, release just after an edge.
  task automatic reset_dut();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_pc !== 32'h0 || out_instruction !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got pc=%h instr=%h want 0/0", out_pc, out_instruction);
    end
    n_checks++;
    if (halted !== 1'b0 || misaligned_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got halted=%b fault=%b want 0/0", halted, misaligned_fault);
    end
    n_checks++;
    if (rom_address !== 32'h0) begin n_fail++; $display("FAIL reset_rom_address: got %h want 0", rom_address); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    reset_dut();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h00b00093) begin
      n_fail++; $display("FAIL stream_first: got v=%b pc=%h instr=%h want 1/0/00b00093", out_valid, out_pc, out_instruction);
    end
    n_checks++;
    if (rom_address !== 32'h4) begin n_fail++; $display("FAIL stream_rom_addr0: got %h want 4", rom_address); end
    for (int k = 1; k < 5; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instruction !== rom_word(32'(4 * k)) ||
          rom_address !== 32'(4 * k + 4)) begin
        n_fail++;
        $display("FAIL stream_step%0d: got v=%b pc=%h instr=%h addr=%h want 1/%h/%h/%h", k, out_valid, out_pc,
                 out_instruction, rom_address, 32'(4 * k), rom_word(32'(4 * k)), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    reset_dut();
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_address !== 32'h8) begin
      n_fail++; $display("FAIL bp_hold: got v=%b pc=%h addr=%h want 1/0/8", out_valid, out_pc, rom_address);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instruction !== rom_word(32'(4 * k))) begin
        n_fail++; $display("FAIL bp_drain%0d: got v=%b pc=%h want 1/%h", k, out_valid, out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    reset_dut();
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || rom_address !== 32'h10) begin
      n_fail++; $display("FAIL redirect_flush: got v=%b addr=%h want 0/10", out_valid, rom_address);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instruction !== rom_word(32'h10)) begin
      n_fail++; $display("FAIL redirect_target: got v=%b pc=%h want 1/10", out_valid, out_pc);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14) begin
      n_fail++; $display("FAIL redirect_next: got v=%b pc=%h want 1/14", out_valid, out_pc);
    end
  endtask

  task automatic test_halt();
    int cycles;
    out_ready = 1'b1;
    reset_dut();
    cycles = 0;
    tick();
    while (out_pc !== 32'h7C && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (out_pc !== 32'h7C || cycles != 31) begin
      n_fail++; $display("FAIL halt_reach_last: got pc=%h after %0d cycles want 7c after 31", out_pc, cycles);
    end
    tick();
    n_checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || rom_address !== 32'h80) begin
      n_fail++; $display("FAIL halt_enter: got h=%b v=%b addr=%h want 1/0/80", halted, out_valid, rom_address);
    end
    tick();
    tick();
    n_checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || rom_address !== 32'h80) begin
      n_fail++; $display("FAIL halt_stay: got h=%b v=%b addr=%h want 1/0/80", halted, out_valid, rom_address);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || rom_address !== 32'h0) begin
      n_fail++; $display("FAIL halt_resume: got h=%b v=%b addr=%h want 0/0/0", halted, out_valid, rom_address);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h00b00093) begin
      n_fail++; $display("FAIL halt_refetch: got v=%b pc=%h instr=%h want 1/0/00b00093", out_valid, out_pc, out_instruction);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || rom_address !== 32'h100) begin
      n_fail++; $display("FAIL halt_oor_redirect: got h=%b v=%b addr=%h want 1/0/100", halted, out_valid, rom_address);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    reset_dut();
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || rom_address !== 32'h0) begin
      n_fail++; $display("FAIL midreset_async: got v=%b pc=%h addr=%h want 0/0/0", out_valid, out_pc, rom_address);
    end
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_address !== 32'h4) begin
      n_fail++; $display("FAIL midreset_restart: got v=%b pc=%h addr=%h want 1/0/4", out_valid, out_pc, rom_address);
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    reset_dut();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++;
    if (halted !== 1'b1 || misaligned_fault !== 1'b1 || out_valid !== 1'b0 || rom_address !== 32'h6) begin
      n_fail++; $display("FAIL misalign_fault: got h=%b f=%b v=%b addr=%h want 1/1/0/6", halted, misaligned_fault, out_valid, rom_address);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || misaligned_fault !== 1'b0 || rom_address !== 32'h20) begin
      n_fail++; $display("FAIL misalign_clear: got h=%b f=%b addr=%h want 0/0/20", halted, misaligned_fault, rom_address);
    end
`else
    n_checks++;
    if (halted !== 1'b0 || misaligned_fault !== 1'b0 || rom_address !== 32'h4) begin
      n_fail++; $display("FAIL misalign_forced: got h=%b f=%b addr=%h want 0/0/4", halted, misaligned_fault, rom_address);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instruction !== rom_word(32'h4)) begin
      n_fail++; $display("FAIL misalign_fetch: got v=%b pc=%h want 1/4", out_valid, out_pc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
